vend_sequencer: RTL

//  Control FSM for the 4-product drink machine: accumulates coin credit, round-robin arbitrates
//  the four select buttons, checks price/stock, drives one dispense actuator for a fixed pulse,

---
 rtl/vend_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/vend_sequencer.sv
// Control FSM for a 4-product drink machine: coin credit, round-robin product arbitration,
// timed dispense pulse and coin-by-coin change payout over a valid/ready handshake.
module vend_sequencer #(
    parameter int PRICE0          = 30,
    parameter int PRICE1          = 30,
    parameter int PRICE2          = 30,
    parameter int PRICE3          = 30,
    parameter int STOCK_INIT      = 5,
    parameter int DISPENSE_CYCLES = 4,
    parameter int MAX_CREDIT      = 995
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic [1:0]  coin,
    input  logic [3:0]  sel_req,
    input  logic        cancel,
    input  logic        restock,
    output logic [3:0]  vend_out,
    output logic        vend_done,
    output logic [1:0]  chg_coin,
    output logic        chg_valid,
    input  logic        chg_ready,
    output logic        coin_reject,
    output logic        not_enough,
    output logic        sold_out,
    output logic        busy,
    output logic [15:0] credit,
    output logic [11:0] stock
);

    localparam int CW = (DISPENSE_CYCLES < 1) ? 1 : $clog2(DISPENSE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_DISPENSE, S_CHANGE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [15:0]     r_credit;
    logic [3:0][2:0] r_stock;
    logic [1:0]      r_rr;
    logic [3:0]      r_sel;
    logic [1:0]      r_win;
    logic [CW-1:0]   r_cnt;
    logic            r_coin_reject;
    logic            r_not_enough;
    logic            r_sold_out;

    logic [15:0]     w_coinVal;
    logic [16:0]     w_coinSum;
    logic            w_coinOk;
    logic            w_coinReject;
    logic [1:0]      w_win;
    logic [15:0]     w_price;
    logic            w_soldOut;
    logic            w_notEnough;
    logic            w_grant;
    logic [1:0]      w_chgCoin;
    logic [15:0]     w_chgVal;
    logic            w_chgFire;
    logic            w_dispEnd;

    function automatic logic [15:0] coinValue(input logic [1:0] c);
        case (c)
            2'd1:    return 16'd5;
            2'd2:    return 16'd10;
            2'd3:    return 16'd25;
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [15:0] priceOf(input logic [1:0] p);
        case (p)
            2'd0:    return 16'(PRICE0);
            2'd1:    return 16'(PRICE1);
            2'd2:    return 16'(PRICE2);
            default: return 16'(PRICE3);
        endcase
    endfunction

    assign w_coinVal    = coinValue(coin);
    assign w_coinSum    = {1'b0, r_credit} + {1'b0, w_coinVal};
    assign w_coinOk     = (r_state == S_IDLE) && (coin != 2'd0) && (w_coinSum <= 17'(MAX_CREDIT));
    assign w_coinReject = (coin != 2'd0) && !w_coinOk;

    // Round-robin search over the latched request, starting at the pointer.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        w_win = r_rr;
        for (int i = 0; i < 4; i++) begin
            idx = r_rr + 2'(i);
            if (!found && r_sel[idx]) begin
                w_win = idx;
                found = 1'b1;
            end
        end
    end

    assign w_price     = priceOf(w_win);
    assign w_soldOut   = (r_state == S_ARB) && (r_stock[w_win] == 3'd0);
    assign w_notEnough = (r_state == S_ARB) && (r_stock[w_win] != 3'd0) && (r_credit < w_price);
    assign w_grant     = (r_state == S_ARB) && (r_stock[w_win] != 3'd0) && (r_credit >= w_price);

    assign w_chgCoin = (r_credit >= 16'd25) ? 2'd3 : ((r_credit >= 16'd10) ? 2'd2 : 2'd1);
    assign w_chgVal  = coinValue(w_chgCoin);
    assign w_chgFire = (r_state == S_CHANGE) && chg_ready;
    assign w_dispEnd = (r_cnt == CW'(DISPENSE_CYCLES));

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        vend_out  = 4'b0000;
        vend_done = 1'b0;
        chg_valid = 1'b0;
        chg_coin  = 2'd0;
        case (r_state)
            S_IDLE: begin
                if (cancel && (r_credit != 16'd0)) w_next = S_CHANGE;
                else if (sel_req != 4'b0000)       w_next = S_ARB;
            end
            S_ARB: begin
                w_next = w_grant ? S_DISPENSE : S_IDLE;
            end
            S_DISPENSE: begin
                if (w_dispEnd) begin
                    vend_done = 1'b1;
                    w_next    = (r_credit != 16'd0) ? S_CHANGE : S_IDLE;
                end else begin
                    vend_out = 4'b0001 << r_win;
                end
            end
            S_CHANGE: begin
                chg_valid = 1'b1;
                chg_coin  = w_chgCoin;
                if (w_chgFire && (r_credit == w_chgVal)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Credit, arbitration and dispense bookkeeping; restock overrides a same-cycle vend.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_credit      <= 16'd0;
            r_stock       <= {4{3'(STOCK_INIT)}};
            r_rr          <= 2'd0;
            r_sel         <= 4'b0000;
            r_win         <= 2'd0;
            r_cnt         <= '0;
            r_coin_reject <= 1'b0;
            r_not_enough  <= 1'b0;
            r_sold_out    <= 1'b0;
        end else begin
            r_coin_reject <= w_coinReject;
            r_not_enough  <= w_notEnough;
            r_sold_out    <= w_soldOut;
            case (r_state)
                S_IDLE: begin
                    if (w_coinOk) r_credit <= w_coinSum[15:0];
                    r_sel <= sel_req;
                    r_cnt <= '0;
                end
                S_ARB: begin
                    r_rr  <= w_win + 2'd1;
                    r_win <= w_win;
                    r_cnt <= '0;
                    if (w_grant) r_credit <= r_credit - w_price;
                end
                S_DISPENSE: begin
                    r_cnt <= r_cnt + CW'(1);
                end
                S_CHANGE: begin
                    if (w_chgFire) r_credit <= r_credit - w_chgVal;
                end
                default: ;
            endcase
            if (restock)      r_stock        <= {4{3'(STOCK_INIT)}};
            else if (w_grant) r_stock[w_win] <= r_stock[w_win] - 3'd1;
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign credit      = r_credit;
    assign stock       = r_stock;
    assign coin_reject = r_coin_reject;
    assign not_enough  = r_not_enough;
    assign sold_out    = r_sold_out;

endmodule
